// File: rtl/rom_streamer_if.sv
// Stream/ROM handshake bundle for rom_streamer.
// ROM_STREAM_LOOP_EN adds the in_loop control.
interface rom_streamer_if #(
    parameter int ADDRBITS = 3,
    parameter int DATABITS = 8
);
    logic                in_start;
    logic [ADDRBITS-1:0] in_base_addr;
    logic [ADDRBITS:0]   in_count;
    logic [ADDRBITS-1:0] out_rom_addr;
    logic [DATABITS-1:0] in_rom_data;
    logic [DATABITS-1:0] out_data;
    logic                out_valid;
    logic                in_ready;
    logic                out_last;
    logic                out_busy;
    logic                out_done;
`ifdef ROM_STREAM_LOOP_EN
    logic                in_loop;

    modport master (
        input  in_start, in_base_addr, in_count, in_rom_data, in_ready, in_loop,
        output out_rom_addr, out_data, out_valid, out_last, out_busy, out_done
    );
    modport slave (
        output in_start, in_base_addr, in_count, in_rom_data, in_ready, in_loop,
        input  out_rom_addr, out_data, out_valid, out_last, out_busy, out_done
    );
`else
    modport master (
        input  in_start, in_base_addr, in_count, in_rom_data, in_ready,
        output out_rom_addr, out_data, out_valid, out_last, out_busy, out_done
    );
    modport slave (
        output in_start, in_base_addr, in_count, in_rom_data, in_ready,
        input  out_rom_addr, out_data, out_valid, out_last, out_busy, out_done
    );
`endif
endinterface

// File: rtl/rom_streamer.sv
// Burst reader in front of a combinational ROM, emitting a valid/ready word stream.
// Optional feature macro: ROM_STREAM_LOOP_EN (repeat the burst while in_loop is high).
module rom_streamer #(
    parameter int ADDRBITS = 3,
    parameter int DATABITS = 8
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    rom_streamer_if.master   bus
);
    localparam int                DEPTH_INT = 1 << ADDRBITS;
    localparam logic [ADDRBITS:0] DEPTH     = DEPTH_INT[ADDRBITS:0];
    localparam logic [ADDRBITS:0] ONE_R     = 1;
    localparam logic [ADDRBITS-1:0] ONE_A   = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [ADDRBITS-1:0] addr;
    logic [ADDRBITS:0]   remaining;
    logic [ADDRBITS:0]   clamped_count;
    logic [DATABITS-1:0] data_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;
    logic                load;
    logic                drain;
`ifdef ROM_STREAM_LOOP_EN
    logic [ADDRBITS-1:0] base_q;
    logic [ADDRBITS:0]   count_q;
`endif

    always_comb begin
        clamped_count = (bus.in_count > DEPTH) ? DEPTH : bus.in_count;
        load          = (remaining != '0) && (!valid_q || bus.in_ready);
        drain         = (remaining == '0) && valid_q && bus.in_ready && last_q;
    end

    assign bus.out_rom_addr = addr;
    assign bus.out_data     = data_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_last     = last_q;
    assign bus.out_busy     = busy_q;
    assign bus.out_done     = done_q;

    // In loop builds the final load of a pass parks addr on the base so the
    // ROM already presents the first word when the last word is accepted.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ROM_STREAM_LOOP_EN
            base_q    <= '0;
            count_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.in_start && (bus.in_count != '0)) begin
                        addr      <= bus.in_base_addr;
                        remaining <= clamped_count;
                        busy_q    <= 1'b1;
                        state     <= RUN;
`ifdef ROM_STREAM_LOOP_EN
                        base_q    <= bus.in_base_addr;
                        count_q   <= clamped_count;
`endif
                    end
                end
                RUN: begin
                    if (load) begin
                        data_q    <= bus.in_rom_data;
                        valid_q   <= 1'b1;
                        last_q    <= (remaining == ONE_R);
                        remaining <= remaining - ONE_R;
`ifdef ROM_STREAM_LOOP_EN
                        addr      <= (remaining == ONE_R) ? base_q : addr + ONE_A;
`else
                        addr      <= addr + ONE_A;
`endif
                    end else if (drain) begin
`ifdef ROM_STREAM_LOOP_EN
                        if (bus.in_loop) begin
                            data_q    <= bus.in_rom_data;
                            valid_q   <= 1'b1;
                            last_q    <= (count_q == ONE_R);
                            addr      <= (count_q == ONE_R) ? base_q : base_q + ONE_A;
                            remaining <= count_q - ONE_R;
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end
`else
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
`endif
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer with a ROM model returning 8'hA0 + address.
// Build with ROM_STREAM_LOOP_EN defined to include the looping scenario.
module tb_rom_streamer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rom_streamer_if #(.ADDRBITS(3), .DATABITS(8)) bus ();

    rom_streamer #(.ADDRBITS(3), .DATABITS(8)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus.master)
    );

    assign bus.in_rom_data = 8'hA0 + {5'b0, bus.out_rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " valid"}, {31'b0, bus.out_valid}, 32'd0);
        checkOutput({tag, " busy"},  {31'b0, bus.out_busy},  32'd0);
        checkOutput({tag, " done"},  {31'b0, bus.out_done},  32'd0);
    endtask

    // Starts a burst, then walks it cycle by cycle: every presented word is
    // compared to the hand table, whether it is accepted or stalled.
    task automatic applyStimulus(input string tag, input logic [2:0] base, input logic [3:0] count,
                                 input logic [7:0] ready_pat, input int n_exp, input logic [63:0] exp_words,
                                 input logic [7:0] last_mask, input bit poke_start, input bit use_loop);
        int  idx;
        bit  finished;
        idx      = 0;
        finished = 0;
        bus.in_base_addr = base;
        bus.in_count     = count;
        bus.in_start     = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (poke_start) begin
                bus.in_start     = (cyc == 1 || cyc == 2);
                bus.in_base_addr = 3'd5;
                bus.in_count     = 4'd3;
            end
            bus.in_ready = ready_pat[cyc % 8];
`ifdef ROM_STREAM_LOOP_EN
            bus.in_loop = use_loop && (idx < n_exp - 2);
`endif
            checkOutput({tag, " busy"}, {31'b0, bus.out_busy}, 32'd1);
            checkOutput({tag, " done early"}, {31'b0, bus.out_done}, 32'd0);
            if (bus.out_valid) begin
                checkOutput({tag, " data"}, {24'b0, bus.out_data}, {24'b0, exp_words[8*idx +: 8]});
                checkOutput({tag, " last"}, {31'b0, bus.out_last}, {31'b0, last_mask[idx]});
                if (bus.in_ready) idx++;
            end
            if (idx == n_exp) finished = 1;
            @(posedge clk); #1;
        end
        bus.in_start = 1'b0;
        bus.in_ready = 1'b1;
`ifdef ROM_STREAM_LOOP_EN
        bus.in_loop = 1'b0;
`endif
        if (!finished) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
        checkOutput({tag, " drain valid"}, {31'b0, bus.out_valid}, 32'd0);
        checkOutput({tag, " done pulse"},  {31'b0, bus.out_done},  32'd1);
        checkOutput({tag, " done busy"},   {31'b0, bus.out_busy},  32'd0);
        @(posedge clk); #1;
        checkIdle({tag, " after done"});
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_start = 1'b0;
        bus.in_base_addr = '0;
        bus.in_count = '0;
        bus.in_ready = 1'b1;
`ifdef ROM_STREAM_LOOP_EN
        bus.in_loop  = 1'b0;
`endif
        #12;
        checkIdle("reset");
        checkOutput("reset data", {24'b0, bus.out_data}, 32'd0);
        checkOutput("reset addr", {29'b0, bus.out_rom_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort mid-burst: outputs clear without waiting for a clock edge.
        bus.in_base_addr = 3'd2;
        bus.in_count     = 4'd4;
        bus.in_start     = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("midburst valid", {31'b0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkIdle("async reset");
        checkOutput("async reset data", {24'b0, bus.out_data}, 32'd0);
        checkOutput("async reset last", {31'b0, bus.out_last}, 32'd0);
        checkOutput("async reset addr", {29'b0, bus.out_rom_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkIdle("post reset");
        end

        applyStimulus("base2", 3'd2, 4'd4, 8'hFF, 4, 64'h00000000_A5A4A3A2, 8'h08, 0, 0);
`ifndef ROM_STREAM_LOOP_EN
        checkOutput("base2 end addr", {29'b0, bus.out_rom_addr}, 32'd6);
`endif
        applyStimulus("wrap", 3'd6, 4'd4, 8'hFF, 4, 64'h00000000_A1A0A7A6, 8'h08, 0, 0);
        applyStimulus("stall", 3'd0, 4'd3, 8'h99, 3, 64'h00000000_00A2A1A0, 8'h04, 0, 0);
        applyStimulus("clamp", 3'd4, 4'd9, 8'hFF, 8, 64'hA3A2A1A0_A7A6A5A4, 8'h80, 0, 0);
`ifndef ROM_STREAM_LOOP_EN
        checkOutput("clamp end addr", {29'b0, bus.out_rom_addr}, 32'd4);
`endif

        // A zero count must never leave IDLE.
        bus.in_base_addr = 3'd3;
        bus.in_count     = 4'd0;
        bus.in_start     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkIdle("count0");
        end
        bus.in_start = 1'b0;

        applyStimulus("start in run", 3'd0, 4'd2, 8'hFF, 2, 64'h00000000_0000A1A0, 8'h02, 1, 0);
`ifdef ROM_STREAM_LOOP_EN
        applyStimulus("loop", 3'd1, 4'd2, 8'hFF, 6, 64'h0000A2A1_A2A1A2A1, 8'h2A, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
